// File: rtl/uart_cmd_slave.sv
// UART command slave: decodes write (2-byte) and read (1-byte) commands onto a local register bus
// and answers reads with one frame on tx. Define UART_SLV_PARITY_EN for 11-bit odd-parity frames.
module uart_cmd_slave #(
  parameter int BR_DIV = 434,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  output logic              o_tx,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_rd_vld,
  output logic              o_frame_err,
  output logic              o_ovr_err,
  output logic              o_busy
);

`ifdef UART_SLV_PARITY_EN
  localparam int LP_NBITS = 11;
`else
  localparam int LP_NBITS = 10;
`endif
  localparam logic [3:0] LP_LAST   = 4'(LP_NBITS - 1);
  localparam logic [8:0] LP_DIV_M1 = 9'(BR_DIV - 1);
  localparam logic [8:0] LP_HALF   = 9'(BR_DIV / 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LO, S_RD_WAIT, S_TX} state_t;

  logic              r_rx_s1, r_rx_s2, r_rx_d;
  logic              r_rx_act;
  logic [8:0]        r_rx_cnt;
  logic [3:0]        r_rx_bit;
  logic [DATA_W-1:0] r_rx_sh;
  logic              r_byte_done;
  logic              r_frame_err;
  logic              w_par_bad;

  state_t              r_state;
  logic                r_ovr_err;
  logic                r_tx;
  logic [LP_NBITS-1:0] r_tx_sh;
  logic [8:0]          r_tx_cnt;
  logic [3:0]          r_tx_bit;
  logic [LP_NBITS-1:0] w_tx_frame;

`ifdef UART_SLV_PARITY_EN
  logic r_rx_par;
  assign w_par_bad  = ~(^{r_rx_sh, r_rx_par});
  assign w_tx_frame = {1'b0, i_rd_data, ~(^i_rd_data), 1'b1};
`else
  assign w_par_bad  = 1'b0;
  assign w_tx_frame = {1'b0, i_rd_data, 1'b1};
`endif

  // Receiver: bit index 0 is start, 1..8 data, optional parity, LP_LAST is stop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_d      <= 1'b1;
      r_rx_act    <= 1'b0;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_sh     <= '0;
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_SLV_PARITY_EN
      r_rx_par    <= 1'b0;
`endif
    end else begin
      r_rx_s1     <= i_rx;
      r_rx_s2     <= r_rx_s1;
      r_rx_d      <= r_rx_s2;
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
      if (!r_rx_act) begin
        if (r_rx_d && !r_rx_s2) begin
          r_rx_act <= 1'b1;
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end
      end else if (r_rx_cnt == LP_HALF) begin
        r_rx_cnt <= r_rx_cnt + 9'd1;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_s2) r_rx_act <= 1'b0;
        end else if (r_rx_bit == LP_LAST) begin
          r_rx_act <= 1'b0;
          if (!r_rx_s2 || w_par_bad) r_frame_err <= 1'b1;
          else                       r_byte_done <= 1'b1;
`ifdef UART_SLV_PARITY_EN
        end else if (r_rx_bit == 4'd9) begin
          r_rx_par <= r_rx_s2;
`endif
        end else begin
          r_rx_sh <= {r_rx_sh[DATA_W-2:0], r_rx_s2};
        end
      end else if (r_rx_cnt == LP_DIV_M1) begin
        r_rx_cnt <= '0;
        r_rx_bit <= r_rx_bit + 4'd1;
      end else begin
        r_rx_cnt <= r_rx_cnt + 9'd1;
      end
    end
  end

  // Command FSM with the transmitter folded into the TX state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_rd_req  <= 1'b0;
      o_rd_addr <= '0;
      r_ovr_err <= 1'b0;
      r_tx      <= 1'b1;
      r_tx_sh   <= '0;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
    end else begin
      o_wr_en   <= 1'b0;
      o_rd_req  <= 1'b0;
      r_ovr_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_byte_done) begin
            if (r_rx_sh[DATA_W-1]) begin
              o_wr_addr <= r_rx_sh[ADDR_W-1:0];
              r_state   <= S_WAIT_LO;
            end else begin
              o_rd_req  <= 1'b1;
              o_rd_addr <= r_rx_sh[ADDR_W-1:0];
              r_state   <= S_RD_WAIT;
            end
          end
        end
        S_WAIT_LO: begin
          if (r_frame_err) begin
            r_state <= S_IDLE;
          end else if (r_byte_done) begin
            o_wr_en   <= 1'b1;
            o_wr_data <= r_rx_sh;
            r_state   <= S_IDLE;
          end
        end
        S_RD_WAIT: begin
          if (r_byte_done) r_ovr_err <= 1'b1;
          if (i_rd_vld) begin
            r_tx_sh  <= w_tx_frame;
            r_tx     <= w_tx_frame[LP_NBITS-1];
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_state  <= S_TX;
          end
        end
        S_TX: begin
          if (r_byte_done) r_ovr_err <= 1'b1;
          if (r_tx_cnt == LP_DIV_M1) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == LP_LAST) begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_tx_bit <= r_tx_bit + 4'd1;
              r_tx     <= r_tx_sh[LP_NBITS-2];
              r_tx_sh  <= {r_tx_sh[LP_NBITS-2:0], 1'b0};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 9'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx        = r_tx;
  assign o_frame_err = r_frame_err;
  assign o_ovr_err   = r_ovr_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Directed bench for uart_cmd_slave at BR_DIV=8; frame width follows UART_SLV_PARITY_EN.
module tb_uart_cmd_slave;
  localparam int BR = 8;
`ifdef UART_SLV_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_vld = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       tx, wr_en, rd_req, frame_err, ovr_err, busy;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  int total = 0;
  int bad = 0;
  int n_wr = 0, n_rd = 0, n_fe = 0, n_ovr = 0;
  logic [6:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  uart_cmd_slave #(.BR_DIV(BR), .ADDR_W(7), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx), .o_tx(tx),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .i_rd_vld(rd_vld),
    .o_frame_err(frame_err), .o_ovr_err(ovr_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (rd_req)    n_rd++;
    if (frame_err) n_fe++;
    if (ovr_err)   n_ovr++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NB-1:0] frm(input logic [7:0] d, input logic bad_stop);
    logic [NB-1:0] f;
`ifdef UART_SLV_PARITY_EN
    f = {1'b0, d, ~(^d), ~bad_stop};
`else
    f = {1'b0, d, ~bad_stop};
`endif
    return f;
  endfunction

  task automatic send_frame(input logic [NB-1:0] f);
    for (int i = NB - 1; i >= 0; i--) begin
      rx = f[i];
      tick(BR);
    end
    rx = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_stop);
    send_frame(frm(d, bad_stop));
  endtask

  task automatic pulse_rd_vld(input logic [7:0] d);
    rd_data = d;
    rd_vld  = 1'b1;
    tick(1);
    rd_vld  = 1'b0;
  endtask

  task automatic test_reset;
    tick(3);
    total++; if (tx !== 1'b1)      begin bad++; $display("FAIL rst_tx got=%b want=1", tx); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (wr_en !== 1'b0 || rd_req !== 1'b0) begin bad++; $display("FAIL rst_strobes wr_en=%b rd_req=%b want=0,0", wr_en, rd_req); end
    total++; if (frame_err !== 1'b0 || ovr_err !== 1'b0) begin bad++; $display("FAIL rst_errs fe=%b ovr=%b want=0,0", frame_err, ovr_err); end
    total++; if (wr_addr !== 7'h00 || wr_data !== 8'h00 || rd_addr !== 7'h00) begin bad++; $display("FAIL rst_regs wa=%h wd=%h ra=%h want=0,0,0", wr_addr, wr_data, rd_addr); end
    rst = 1'b0;
    tick(5);
    total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_rst_idle tx=%b busy=%b want=1,0", tx, busy); end
  endtask

  task automatic test_write;
    int w0;
    w0 = n_wr;
    send_byte(8'h85, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_mid got=%b want=1", busy); end
    total++; if (n_wr != w0)    begin bad++; $display("FAIL wr_early got=%0d want=%0d", n_wr - w0, 0); end
    send_byte(8'h3C, 1'b0);
    total++; if (n_wr != w0 + 1) begin bad++; $display("FAIL wr_count got=%0d want=1", n_wr - w0); end
    total++; if (last_wa !== 7'h05 || last_wd !== 8'h3C) begin bad++; $display("FAIL wr_bus addr=%h data=%h want=05,3c", last_wa, last_wd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_read;
    int r0;
    logic found;
    logic [NB-1:0] exp_f;
`ifdef UART_SLV_PARITY_EN
    exp_f = 11'b0_10100101_1_1;
`else
    exp_f = 10'b0_10100101_1;
`endif
    r0 = n_rd;
    send_byte(8'h12, 1'b0);
    total++; if (n_rd != r0 + 1) begin bad++; $display("FAIL rd_req_count got=%0d want=1", n_rd - r0); end
    total++; if (rd_addr !== 7'h12 || busy !== 1'b1) begin bad++; $display("FAIL rd_req_addr addr=%h busy=%b want=12,1", rd_addr, busy); end
    tick(16);
    pulse_rd_vld(8'hA5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rd_tx_start got=no start bit want=start within 20 clks");
    end else begin
      for (int b = 0; b < NB; b++) begin
        total++; if (tx !== exp_f[NB-1-b]) begin bad++; $display("FAIL rd_tx_bit%0d_first got=%b want=%b", b, tx, exp_f[NB-1-b]); end
        repeat (BR - 1) @(negedge clk);
        total++; if (tx !== exp_f[NB-1-b]) begin bad++; $display("FAIL rd_tx_bit%0d_last got=%b want=%b", b, tx, exp_f[NB-1-b]); end
        @(negedge clk);
      end
      total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rd_tx_end tx=%b busy=%b want=1,0", tx, busy); end
    end
  endtask

`ifdef UART_SLV_PARITY_EN
  task automatic test_parity_err;
    int f0, w0;
    logic [NB-1:0] f;
    f0 = n_fe; w0 = n_wr;
    f = frm(8'h85, 1'b0);
    f[1] = ~f[1];
    send_frame(f);
    total++; if (n_fe != f0 + 1) begin bad++; $display("FAIL par_fe got=%0d want=1", n_fe - f0); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL par_busy got=%b want=0", busy); end
    send_byte(8'h85, 1'b0);
    send_byte(8'h01, 1'b0);
    total++; if (n_wr != w0 + 1 || last_wa !== 7'h05 || last_wd !== 8'h01) begin bad++; $display("FAIL par_recover n=%0d addr=%h data=%h want=1,05,01", n_wr - w0, last_wa, last_wd); end
  endtask
`endif

  task automatic test_stop_err;
    int f0, w0;
    f0 = n_fe; w0 = n_wr;
    send_byte(8'h85, 1'b0);
    send_byte(8'h22, 1'b1);
    total++; if (n_fe != f0 + 1) begin bad++; $display("FAIL stop_fe got=%0d want=1", n_fe - f0); end
    total++; if (n_wr != w0)     begin bad++; $display("FAIL stop_no_wr got=%0d want=0", n_wr - w0); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL stop_idle busy=%b want=0", busy); end
    send_byte(8'h85, 1'b0);
    send_byte(8'h01, 1'b0);
    total++; if (n_wr != w0 + 1 || last_wa !== 7'h05 || last_wd !== 8'h01) begin bad++; $display("FAIL stop_recover n=%0d addr=%h data=%h want=1,05,01", n_wr - w0, last_wa, last_wd); end
  endtask

  task automatic test_overrun_glitch;
    int r0, o0, f0;
    r0 = n_rd; o0 = n_ovr; f0 = n_fe;
    send_byte(8'h12, 1'b0);
    send_byte(8'h7F, 1'b0);
    total++; if (n_ovr != o0 + 1) begin bad++; $display("FAIL ovr_pulse got=%0d want=1", n_ovr - o0); end
    total++; if (rd_addr !== 7'h12 || n_rd != r0 + 1) begin bad++; $display("FAIL ovr_rd_hold addr=%h reqs=%0d want=12,1", rd_addr, n_rd - r0); end
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(30);
    total++; if (n_ovr != o0 + 1 || n_fe != f0) begin bad++; $display("FAIL glitch ovr=%0d fe=%0d want=1,0", n_ovr - o0, n_fe - f0); end
    pulse_rd_vld(8'h00);
    tick(NB * BR + 5);
    total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL ovr_done busy=%b tx=%b want=0,1", busy, tx); end
  endtask

  task automatic test_reset_mid_tx;
    int r0;
    logic found;
    send_byte(8'h01, 1'b0);
    tick(3);
    pulse_rd_vld(8'h5A);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rmt_start got=no start bit want=start"); end
    repeat (4 * BR + 4) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmt_async tx=%b busy=%b want=1,0", tx, busy); end
    tick(2);
    rst = 1'b0;
    tick(3);
    r0 = n_rd;
    send_byte(8'h01, 1'b0);
    total++; if (n_rd != r0 + 1 || rd_addr !== 7'h01) begin bad++; $display("FAIL rmt_read reqs=%0d addr=%h want=1,01", n_rd - r0, rd_addr); end
    tick(2);
    pulse_rd_vld(8'h3C);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rmt_tx2_start got=no start bit want=start"); end
    repeat (NB * BR) @(negedge clk);
    total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmt_tx2_end tx=%b busy=%b want=1,0", tx, busy); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
`ifdef UART_SLV_PARITY_EN
    test_parity_err;
`endif
    test_stop_err;
    test_overrun_glitch;
    test_reset_mid_tx;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
